// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC and a word-addressed instruction memory that a loader can write.
// Hazard freeze stalls PC and IF/ID, and an EXE-resolved branch redirects the PC and flushes IF/ID.
// The branch wins over the freeze because it comes from an older instruction.
// Every output toward decode comes straight from a flop.
module if_fetch_stage #(
  parameter int          IMEM_DEPTH  = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0000,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out,
  output logic [31:0] fetch_pc
);

  localparam int AW = $clog2(IMEM_DEPTH);

  // Instruction storage; it has no reset, so contents survive rst.
  logic [31:0] imem_q [IMEM_DEPTH];

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] inst_q;
  logic [31:0] inst_d;
  logic [31:0] pc_out_q;
  logic [31:0] pc_out_d;
  logic        valid_q;
  logic        valid_d;

  logic [31:0] fetch_word_s;
  logic [31:0] pc_plus4_s;
  logic        unused_s;

  // Word index from PC; bits [1:0] and bits above the memory size are dropped so fetches wrap.
  assign fetch_word_s = imem_q[pc_q[AW+1:2]];
  assign pc_plus4_s   = pc_q + 32'd4;

  // Bits of the loader address that do not select a word.
  assign unused_s = ^{imem_waddr[31:AW+2], imem_waddr[1:0]};

  // Loader write port. It is not blocked by rst, freeze or branch.
  // The fetch path reads the pre-edge word, so a same-cycle write gives read-before-write.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_q[imem_waddr[AW+1:2]] <= imem_wdata;
    end
  end

  // Next PC, in priority order: redirect, then stall, then sequential advance (wraps at 2^32).
  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = branch_addr;
    end else if (freeze) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus4_s;
    end
  end

  // Next IF/ID contents with the same priority: flush to a bubble, hold, or capture the fetched word.
  always_comb begin
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (branch_taken) begin
      inst_d   = BUBBLE_INST;
      pc_out_d = 32'h0000_0000;
      valid_d  = 1'b0;
    end else if (freeze) begin
      inst_d   = inst_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
    end else begin
      inst_d   = fetch_word_s;
      pc_out_d = pc_plus4_s;
      valid_d  = 1'b1;
    end
  end

  // PC and IF/ID state. The reset takes effect immediately and inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      inst_q   <= BUBBLE_INST;
      pc_out_q <= 32'h0000_0000;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign pc_out    = pc_out_q;
  assign inst_out  = inst_q;
  assign valid_out = valid_q;
  assign fetch_pc  = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a behavioural fetch model checked on every negedge,
// plus literal expectations at the key points of each directed scenario.
module tb_if_fetch_stage;

  localparam logic [31:0] BUB = 32'h0000_0013;
  localparam logic [31:0] WA  = 32'hA000_000A;
  localparam logic [31:0] WB  = 32'hB000_000B;
  localparam logic [31:0] WC  = 32'hC000_000C;
  localparam logic [31:0] WD  = 32'hD000_000D;
  localparam logic [31:0] WE  = 32'hE000_000E;
  localparam logic [31:0] WF  = 32'hF000_000F;
  localparam logic [31:0] WG  = 32'h6600_0066;
  localparam logic [31:0] WX  = 32'h5858_5858;
  localparam logic [31:0] WH  = 32'h4848_4848;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_we = 1'b0;
  logic [31:0] imem_waddr = 32'h0;
  logic [31:0] imem_wdata = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;
  logic [31:0] fetch_pc;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model state
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pcout;
  logic        m_valid;

  if_fetch_stage #(
    .IMEM_DEPTH (64),
    .RESET_PC   (32'h0000_0000),
    .BUBBLE_INST(BUB),
    .INIT_FILE  ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .pc_out      (pc_out),
    .inst_out    (inst_out),
    .valid_out   (valid_out),
    .fetch_pc    (fetch_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] word_for(input int i);
    case (i)
      0:       return WA;
      1:       return WB;
      2:       return WC;
      3:       return WD;
      4:       return WE;
      5:       return WF;
      63:      return WG;
      default: return 32'hC0DE_0000 | 32'(i);
    endcase
  endfunction

  // Model: memory is a 64-word array addressed modulo its size; the pipeline register follows the stage rules
  always @(posedge clk or posedge rst) begin
    if (clk) begin
      if (imem_we) m_mem[(imem_waddr / 32'd4) % 32'd64] <= imem_wdata;
    end
    if (rst) begin
      m_pc    <= 32'h0;
      m_inst  <= BUB;
      m_pcout <= 32'h0;
      m_valid <= 1'b0;
    end else if (clk) begin
      if (branch_taken) begin
        m_pc    <= branch_addr;
        m_inst  <= BUB;
        m_pcout <= 32'h0;
        m_valid <= 1'b0;
      end else if (!freeze) begin
        m_inst  <= m_mem[(m_pc / 32'd4) % 32'd64];
        m_pcout <= m_pc + 32'd4;
        m_valid <= 1'b1;
        m_pc    <= m_pc + 32'd4;
      end
    end
  end

  // Compare process: DUT against model every cycle once the image is loaded
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_inst", inst_out, m_inst);
      chk("model_pc_out", pc_out, m_pcout);
      chk("model_valid", 32'(valid_out), 32'(m_valid));
      chk("model_fetch_pc", fetch_pc, m_pc);
    end
  end

  initial begin
    // Load the whole memory through the loader port while reset is held
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); #1;
      imem_we    = 1'b1;
      imem_waddr = 32'(i) * 32'd4;
      imem_wdata = word_for(i);
    end
    @(negedge clk); #1;
    imem_we = 1'b0;
    chk("reset_inst", inst_out, BUB);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_fetch_pc", fetch_pc, 32'h0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Sequential fetch
    @(negedge clk);
    chk("t1_e1_inst", inst_out, WA);
    chk("t1_e1_pc_out", pc_out, 32'd4);
    chk("t1_e1_valid", 32'(valid_out), 32'd1);
    @(negedge clk);
    chk("t1_e2_inst", inst_out, WB);
    chk("t1_e2_pc_out", pc_out, 32'd8);

    // Freeze for two edges
    #1 freeze = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t2_hold_inst", inst_out, WB);
      chk("t2_hold_pc_out", pc_out, 32'd8);
      chk("t2_hold_fetch_pc", fetch_pc, 32'd8);
    end
    #1 freeze = 1'b0;
    @(negedge clk);
    chk("t2_release_inst", inst_out, WC);
    chk("t2_release_pc_out", pc_out, 32'd12);

    // Branch with freeze in the same cycle
    #1; branch_taken = 1'b1; branch_addr = 32'h10; freeze = 1'b1;
    @(negedge clk);
    chk("t3_flush_inst", inst_out, BUB);
    chk("t3_flush_valid", 32'(valid_out), 32'd0);
    chk("t3_flush_pc_out", pc_out, 32'd0);
    chk("t3_flush_fetch_pc", fetch_pc, 32'h10);
    #1; branch_taken = 1'b0; freeze = 1'b0;
    @(negedge clk);
    chk("t3_target_inst", inst_out, WE);
    chk("t3_target_pc_out", pc_out, 32'h14);

    // Loader write to the word being fetched
    #1; branch_taken = 1'b1; branch_addr = 32'h8;
    @(negedge clk);
    chk("t5_fetch_pc", fetch_pc, 32'h8);
    #1; branch_taken = 1'b0; imem_we = 1'b1; imem_waddr = 32'h8; imem_wdata = WX;
    @(negedge clk);
    chk("t5_old_word", inst_out, WC);
    chk("t5_old_pc_out", pc_out, 32'd12);
    #1; imem_we = 1'b0; branch_taken = 1'b1; branch_addr = 32'h8;
    @(negedge clk);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    chk("t5_new_word", inst_out, WX);

    // Address wrap modulo memory size
    #1; branch_taken = 1'b1; branch_addr = 32'h100;
    @(negedge clk);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    chk("t6_wrap_inst", inst_out, WA);
    chk("t6_wrap_pc_out", pc_out, 32'h104);

    // PC wrap at the top of the 32-bit space
    #1; branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("t6_top_fetch_pc", fetch_pc, 32'hFFFF_FFFC);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    chk("t6_top_inst", inst_out, WG);
    chk("t6_top_pc_out", pc_out, 32'h0);
    chk("t6_top_valid", 32'(valid_out), 32'd1);
    chk("t6_top_fetch_pc_wrap", fetch_pc, 32'h0);
    @(negedge clk);
    chk("t6_after_inst", inst_out, WA);

    // Asynchronous reset mid-cycle, with a loader write while held
    #2 rst = 1'b1;
    #1;
    chk("t4_async_pc_out", pc_out, 32'h0);
    chk("t4_async_inst", inst_out, BUB);
    chk("t4_async_valid", 32'(valid_out), 32'd0);
    chk("t4_async_fetch_pc", fetch_pc, 32'h0);
    imem_we = 1'b1; imem_waddr = 32'h1C; imem_wdata = WH;
    @(negedge clk);
    #1; imem_we = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("t4_post_inst", inst_out, WA);
    chk("t4_post_pc_out", pc_out, 32'd4);
    @(negedge clk);
    chk("t4_mem_kept_b", inst_out, WB);
    @(negedge clk);
    chk("t4_mem_kept_x", inst_out, WX);
    repeat (5) @(negedge clk);
    chk("t4_write_in_reset", inst_out, WH);

    // Mixed stall and redirect run, checked by the model
    #1 freeze = 1'b1;
    repeat (2) @(negedge clk);
    #1; freeze = 1'b0; branch_taken = 1'b1; branch_addr = 32'h0000_00F6;
    @(negedge clk);
    #1 branch_taken = 1'b0;
    repeat (3) @(negedge clk);

    #1 chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
